// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: requester IDs, priority and ownership encodings shared by the data-memory arbiter.
package dmem_arb_pkg;
   localparam logic REQ_CPU      = 1'b0;
   localparam logic REQ_IO       = 1'b1;
   localparam int   LOCK_MAX_DEF = 16;
   typedef enum logic {PRI0 = REQ_CPU, PRI1 = REQ_IO} prio_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_IO} owner_e;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way pick; a lone valid wins, a tie goes to the favoured side.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic  valid0,
   input  logic  valid1,
   input  prio_e prio,
   output logic  grant0,
   output logic  grant1
);
   assign grant0 = valid0 & (~valid1 | (prio == PRI0));
   assign grant1 = valid1 & (~valid0 | (prio == PRI1));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter of one 8-bit data memory between CPU (port 0) and I/O (port 1).
// Optional ownership locking is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
`ifdef DMEM_ARB_LOCK_EN
   , parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
`ifdef DMEM_ARB_LOCK_EN
   input  logic              req0_lock,
   input  logic              req1_lock,
`endif
   output logic              mem_leitura,
   output logic              mem_escrita,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [DATA_W-1:0] mem_entrada,
   input  logic [DATA_W-1:0] mem_saida
);
   prio_e r_prio, w_sel_prio, w_prio_nx;
   logic  w_p0, w_p1, w_g0, w_g1;

   rr_pick2 u_pick (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .prio   (w_sel_prio),
      .grant0 (w_p0),
      .grant1 (w_p1)
   );

   // Grants are gated by reset so nothing reaches the memory while reset_n is low.
   assign w_g0         = w_p0 & reset_n;
   assign w_g1         = w_p1 & reset_n;
   assign req0_ready   = w_g0;
   assign req1_ready   = w_g1;
   assign mem_escrita  = w_g1 ? req1_we : (w_g0 & req0_we);
   assign mem_leitura  = w_g1 ? ~req1_we : (w_g0 & ~req0_we);
   assign mem_endereco = w_g1 ? req1_addr : (w_g0 ? req0_addr : '0);
   assign mem_entrada  = w_g1 ? req1_wdata : (w_g0 ? req0_wdata : '0);

`ifdef DMEM_ARB_LOCK_EN
   localparam logic [4:0] LOCK_LIM = 5'(LOCK_MAX);
   owner_e     r_owner, w_owner_nx;
   logic [4:0] r_cnt, w_cnt_nx, w_cnt_inc;
   logic       w_lock;

   assign w_sel_prio = (r_owner == OWN_IO) ? PRI1 : ((r_owner == OWN_CPU) ? PRI0 : r_prio);
   // The run length restarts whenever the locking requester differs from the current owner.
   assign w_cnt_inc  = (((r_owner == OWN_IO) & w_g1) | ((r_owner == OWN_CPU) & w_g0) ? r_cnt : 5'd0) + 5'd1;
   assign w_lock     = w_g1 ? req1_lock : (w_g0 & req0_lock);

   always_comb begin
      w_owner_nx = OWN_NONE;
      w_cnt_nx   = '0;
      w_prio_nx  = w_g0 ? PRI1 : (w_g1 ? PRI0 : r_prio);
      if (w_lock && w_cnt_inc != LOCK_LIM) begin
         w_owner_nx = w_g1 ? OWN_IO : OWN_CPU;
         w_cnt_nx   = w_cnt_inc;
         w_prio_nx  = r_prio;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_owner <= OWN_NONE;
         r_cnt   <= '0;
      end else begin
         r_owner <= w_owner_nx;
         r_cnt   <= w_cnt_nx;
      end
   end
`else
   assign w_sel_prio = r_prio;
   assign w_prio_nx  = w_g0 ? PRI1 : (w_g1 ? PRI0 : r_prio);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prio      <= PRI0;
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         req0_rdata  <= '0;
         req1_rdata  <= '0;
      end else begin
         r_prio      <= w_prio_nx;
         req0_rvalid <= w_g0 & ~req0_we;
         req1_rvalid <= w_g1 & ~req1_we;
         if (w_g0 & ~req0_we) req0_rdata <= mem_saida;
         if (w_g1 & ~req1_we) req1_rdata <= mem_saida;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a read-return scoreboard for dmem_arbiter.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
   logic [7:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
   logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
   logic [7:0] req0_rdata, req1_rdata;
   logic       req0_lock = 1'b0, req1_lock = 1'b0;
   logic       mem_leitura, mem_escrita;
   logic [7:0] mem_endereco, mem_entrada, mem_saida;
   logic [7:0] mem [256];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       q0[$], q1[$];
   exp_t       e0, e1;

   dmem_arbiter dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req0_valid   (req0_valid),
      .req0_we      (req0_we),
      .req0_addr    (req0_addr),
      .req0_wdata   (req0_wdata),
      .req0_ready   (req0_ready),
      .req0_rvalid  (req0_rvalid),
      .req0_rdata   (req0_rdata),
      .req1_valid   (req1_valid),
      .req1_we      (req1_we),
      .req1_addr    (req1_addr),
      .req1_wdata   (req1_wdata),
      .req1_ready   (req1_ready),
      .req1_rvalid  (req1_rvalid),
      .req1_rdata   (req1_rdata),
`ifdef DMEM_ARB_LOCK_EN
      .req0_lock    (req0_lock),
      .req1_lock    (req1_lock),
`endif
      .mem_leitura  (mem_leitura),
      .mem_escrita  (mem_escrita),
      .mem_endereco (mem_endereco),
      .mem_entrada  (mem_entrada),
      .mem_saida    (mem_saida)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign mem_saida = mem[mem_endereco];
   always @(negedge clock) if (mem_escrita) mem[mem_endereco] <= mem_entrada;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      nxt();
      reset_n = 1'b0;
      nxt();
      nxt();
      reset_n = 1'b1;
   endtask

   // Read-return monitor: every rvalid pulse must match the oldest expected return.
   always @(negedge clock) begin
      if (reset_n && req0_rvalid) begin
         if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
         else begin
            e0 = q0.pop_front();
            chk("rdata0", {24'd0, req0_rdata}, {24'd0, e0.d});
            chk("rlat0", cyc, e0.cyc);
         end
      end
      if (reset_n && req1_rvalid) begin
         if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("rdata1", {24'd0, req1_rdata}, {24'd0, e1.d});
            chk("rlat1", cyc, e1.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h5A;
      mem[8'h50] = 8'h11;
      // Test 1: reset state, then a lone read of 0x10.
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
      nxt();
      nxt();
      #3;
      chk("rst_ready0", {31'd0, req0_ready}, 0);
      chk("rst_strobes", {30'd0, mem_leitura, mem_escrita}, 0);
      chk("rst_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 0);
      chk("rst_rdata", {16'd0, req1_rdata, req0_rdata}, 0);
      nxt();
      reset_n = 1'b1;
      #3;
      chk("t1_ready0", {31'd0, req0_ready}, 1);
      chk("t1_escrita", {31'd0, mem_escrita}, 0);
      chk("t1_leitura", {31'd0, mem_leitura}, 1);
      chk("t1_addr", {24'd0, mem_endereco}, 32'h10);
      q0.push_back('{cyc + 1, 8'h5A});
      nxt();
      req0_valid = 1'b0;
      #3;
      chk("t1_escrita_idle", {31'd0, mem_escrita}, 0);
      nxt();
      nxt();
      // Test 2: both writing continuously from reset alternate 0,1,0,1.
      do_reset();
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h20; req0_wdata = 8'h01;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h21; req1_wdata = 8'h02;
      for (int k = 0; k < 4; k++) begin
         #3;
         chk("t2_grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
         nxt();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t2_mem20", {24'd0, mem[8'h20]}, 32'h01);
      chk("t2_mem21", {24'd0, mem[8'h21]}, 32'h02);
      // Test 3: read-after-write across requesters.
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h30; req1_wdata = 8'hA5;
      #3;
      chk("t3_ready1", {31'd0, req1_ready}, 1);
      nxt();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h30;
      #3;
      chk("t3_ready0", {31'd0, req0_ready}, 1);
      q0.push_back('{cyc + 1, 8'hA5});
      nxt();
      req0_valid = 1'b0;
      // Test 4: same-address conflict with req1 favoured.
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h40;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h40; req1_wdata = 8'h77;
      #3;
      chk("t4_grant_a", {30'd0, req1_ready, req0_ready}, 2);
      nxt();
      req1_valid = 1'b0;
      #3;
      chk("t4_grant_b", {30'd0, req1_ready, req0_ready}, 1);
      q0.push_back('{cyc + 1, 8'h77});
      nxt();
      req0_valid = 1'b0;
      nxt();
      // Test 5: reset lands inside a write cycle before its negedge.
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h50; req0_wdata = 8'h99;
      #1;
      chk("t5_ready0", {31'd0, req0_ready}, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t5_ready_rst", {30'd0, req1_ready, req0_ready}, 0);
      chk("t5_strobes_rst", {30'd0, mem_leitura, mem_escrita}, 0);
      nxt();
      req0_valid = 1'b0;
      chk("t5_mem50", {24'd0, mem[8'h50]}, 32'h11);
      nxt();
      reset_n = 1'b1;
      chk("t5_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 0);
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h70; req0_wdata = 8'h12;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h71; req1_wdata = 8'h34;
      #3;
      chk("t5_prio_pri0", {30'd0, req1_ready, req0_ready}, 1);
      nxt();
      req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      // Test 6: req1 keeps a lock for LOCK_MAX grants, then req0 gets through.
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h61; req0_wdata = 8'hC0;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h60; req1_wdata = 8'hC1; req1_lock = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #3;
         chk("t6_locked", {30'd0, req1_ready, req0_ready}, 2);
         nxt();
      end
      #3;
      chk("t6_release", {30'd0, req1_ready, req0_ready}, 1);
      nxt();
      req0_valid = 1'b0; req1_valid = 1'b0; req1_lock = 1'b0;
`endif
      nxt();
      nxt();
      chk("q_drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
